cpu_6502_ea_sequencer: RTL and testbench

- Multi-cycle effective-address (EA) generator for the 6502 core.
- Takes an addressing mode plus PC/X/Y. Fetches operand and pointer bytes over a single-outstanding memory read port. Returns the EA, a page-cross flag and the operand byte count.
- Sits between the decoder and the ALU/memory mux and replaces the fixed EX_FOP1/FOP2/EX_ABS/EX_IND sequence with one parametrised sequencer.
- Adds banked addresses, a relocatable zero page and page-cross reporting.

---
 rtl/cpu_6502_ea_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cpu_6502_ea_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_6502_ea_sequencer.sv
// 6502 effective-address sequencer.
// Fetches operand and pointer bytes over a single-outstanding read port and
// returns the EA, a page-cross flag and the operand byte count.
// Optional build macro: JMP_IND_PAGEFIX_EN makes the ABSOLUTE_INDIRECT
// pointer high-byte fetch carry into the pointer high byte (full 16-bit
// increment); without it the NMOS page-wrap behaviour is kept.
module cpu_6502_ea_sequencer #(
  parameter int unsigned ADDR_W  = 16,
  parameter logic [15:0] ZP_BASE = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              start_i,
  input  logic [3:0]        mode_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [7:0]        x_i,
  input  logic [7:0]        y_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ea_o,
  output logic              page_cross_o,
  output logic [1:0]        nbytes_o,
  output logic              err_o
);

  localparam logic [3:0] M_IMP  = 4'd0;
  localparam logic [3:0] M_ACC  = 4'd1;
  localparam logic [3:0] M_IMM  = 4'd2;
  localparam logic [3:0] M_ABS  = 4'd3;
  localparam logic [3:0] M_ABSX = 4'd4;
  localparam logic [3:0] M_ABSY = 4'd5;
  localparam logic [3:0] M_ZP   = 4'd6;
  localparam logic [3:0] M_ZPX  = 4'd7;
  localparam logic [3:0] M_ZPY  = 4'd8;
  localparam logic [3:0] M_INDX = 4'd9;
  localparam logic [3:0] M_INDY = 4'd10;
  localparam logic [3:0] M_AIND = 4'd11;
  localparam logic [3:0] M_REL  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_LO,
    S_OP_HI,
    S_PTR_LO,
    S_PTR_HI,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [3:0]        mode_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        x_q;
  logic [7:0]        y_q;
  logic [7:0]        op_lo_q;
  logic [7:0]        op_hi_q;
  logic [7:0]        ptr_lo_q;

  logic [7:0]        idx_c;
  logic [7:0]        lo_sel_c;
  logic [15:0]       sum16_c;
  logic              sum_cross_c;
  logic [ADDR_W-1:0] sum_ea_c;
  logic [ADDR_W-1:0] zp_ea_c;
  logic [7:0]        ptr_byte_c;
  logic [15:0]       pc_inc16_c;
  logic [15:0]       rel16_c;
  logic              rel_cross_c;
  logic [15:0]       aind_hi16_c;
  logic [ADDR_W-1:0] ptr_hi_addr_c;

  // Replace the low 16 bits of an address, keeping its bank.
  function automatic logic [ADDR_W-1:0] with_lo16(input logic [ADDR_W-1:0] base,
                                                   input logic [15:0]       lo16);
    logic [ADDR_W-1:0] r;
    r        = base;
    r[15:0]  = lo16;
    return r;
  endfunction

  // Relocated zero-page address; always bank 0, no carry out of 16 bits.
  function automatic logic [ADDR_W-1:0] zp_addr(input logic [7:0] a);
    logic [ADDR_W-1:0] r;
    r       = '0;
    r[15:0] = ZP_BASE + {8'h00, a};
    return r;
  endfunction

  // Index register applied to the final 16-bit sum for the current mode.
  always_comb begin
    idx_c = 8'h00;
    case (mode_q)
      M_ABSX, M_ZPX:         idx_c = x_q;
      M_ABSY, M_ZPY, M_INDY: idx_c = y_q;
      default:               idx_c = 8'h00;
    endcase
  end

  // Shared address arithmetic; the high byte is always the byte arriving now.
  assign lo_sel_c    = (state_q == S_OP_HI) ? op_lo_q : ptr_lo_q;
  assign sum16_c     = {mem_rdata_i, lo_sel_c} + {8'h00, idx_c};
  assign sum_cross_c = (sum16_c[15:8] != mem_rdata_i);
  assign sum_ea_c    = with_lo16(pc_q, sum16_c);
  assign zp_ea_c     = zp_addr(8'(mem_rdata_i + idx_c));
  assign ptr_byte_c  = (mode_q == M_INDX) ? 8'(mem_rdata_i + x_q) : mem_rdata_i;
  assign pc_inc16_c  = pc_q[15:0] + 16'd1;
  assign rel16_c     = pc_inc16_c + {{8{mem_rdata_i[7]}}, mem_rdata_i};
  assign rel_cross_c = (rel16_c[15:8] != pc_inc16_c[15:8]);

  // Address of the pointed-to high byte for the indirect modes.
`ifdef JMP_IND_PAGEFIX_EN
  assign aind_hi16_c = {op_hi_q, op_lo_q} + 16'd1;
`else
  assign aind_hi16_c = {op_hi_q, 8'(op_lo_q + 8'd1)};
`endif
  assign ptr_hi_addr_c = (mode_q == M_AIND) ? with_lo16(pc_q, aind_hi16_c)
                                            : zp_addr(8'(op_lo_q + 8'd1));

  // Sequencer FSM with registered memory-port and result outputs.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      pc_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      op_lo_q      <= '0;
      op_hi_q      <= '0;
      ptr_lo_q     <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      ea_o         <= '0;
      page_cross_o <= 1'b0;
      nbytes_o     <= 2'd0;
      err_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q <= mode_i;
            pc_q   <= pc_i;
            x_q    <= x_i;
            y_q    <= y_i;
            busy_o <= 1'b1;
            case (mode_i)
              M_IMP, M_ACC: begin
                state_q      <= S_DONE;
                done_o       <= 1'b1;
                ea_o         <= '0;
                page_cross_o <= 1'b0;
                nbytes_o     <= 2'd0;
                err_o        <= 1'b0;
              end
              M_IMM: begin
                state_q      <= S_DONE;
                done_o       <= 1'b1;
                ea_o         <= pc_i;
                page_cross_o <= 1'b0;
                nbytes_o     <= 2'd1;
                err_o        <= 1'b0;
              end
              M_ABS, M_ABSX, M_ABSY, M_ZP, M_ZPX, M_ZPY,
              M_INDX, M_INDY, M_AIND, M_REL: begin
                state_q    <= S_OP_LO;
                mem_req_o  <= 1'b1;
                mem_addr_o <= pc_i;
              end
              default: begin
                state_q      <= S_DONE;
                done_o       <= 1'b1;
                ea_o         <= '0;
                page_cross_o <= 1'b0;
                nbytes_o     <= 2'd0;
                err_o        <= 1'b1;
              end
            endcase
          end
        end

        S_OP_LO: begin
          if (mem_ack_i) begin
            op_lo_q <= ptr_byte_c;
            case (mode_q)
              M_ZP, M_ZPX, M_ZPY: begin
                mem_req_o    <= 1'b0;
                state_q      <= S_DONE;
                done_o       <= 1'b1;
                ea_o         <= zp_ea_c;
                page_cross_o <= 1'b0;
                nbytes_o     <= 2'd1;
                err_o        <= 1'b0;
              end
              M_REL: begin
                mem_req_o    <= 1'b0;
                state_q      <= S_DONE;
                done_o       <= 1'b1;
                ea_o         <= with_lo16(pc_q, rel16_c);
                page_cross_o <= rel_cross_c;
                nbytes_o     <= 2'd1;
                err_o        <= 1'b0;
              end
              M_INDX, M_INDY: begin
                state_q    <= S_PTR_LO;
                mem_addr_o <= zp_addr(ptr_byte_c);
              end
              default: begin
                state_q    <= S_OP_HI;
                mem_addr_o <= with_lo16(pc_q, pc_inc16_c);
              end
            endcase
          end
        end

        S_OP_HI: begin
          if (mem_ack_i) begin
            op_hi_q <= mem_rdata_i;
            if (mode_q == M_AIND) begin
              state_q    <= S_PTR_LO;
              mem_addr_o <= with_lo16(pc_q, {mem_rdata_i, op_lo_q});
            end else begin
              mem_req_o    <= 1'b0;
              state_q      <= S_DONE;
              done_o       <= 1'b1;
              ea_o         <= sum_ea_c;
              page_cross_o <= sum_cross_c;
              nbytes_o     <= 2'd2;
              err_o        <= 1'b0;
            end
          end
        end

        S_PTR_LO: begin
          if (mem_ack_i) begin
            ptr_lo_q   <= mem_rdata_i;
            state_q    <= S_PTR_HI;
            mem_addr_o <= ptr_hi_addr_c;
          end
        end

        S_PTR_HI: begin
          if (mem_ack_i) begin
            mem_req_o    <= 1'b0;
            state_q      <= S_DONE;
            done_o       <= 1'b1;
            ea_o         <= sum_ea_c;
            page_cross_o <= sum_cross_c;
            nbytes_o     <= (mode_q == M_AIND) ? 2'd2 : 2'd1;
            err_o        <= 1'b0;
          end
        end

        S_DONE: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q   <= S_IDLE;
          busy_o    <= 1'b0;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_6502_ea_sequencer.sv
// Scoreboard bench for cpu_6502_ea_sequencer (ADDR_W=20, ZP_BASE=16'h0100).
module tb_cpu_6502_ea_sequencer;

  localparam int unsigned AW = 20;

  typedef struct {
    logic [AW-1:0] ea;
    logic          pcx;
    logic [1:0]    nb;
    logic          err;
    int            tag;
  } exp_t;

`ifdef JMP_IND_PAGEFIX_EN
  localparam logic [AW-1:0] AIND_EA = 20'h05080;
  localparam logic [AW-1:0] AIND_HI = 20'h03100;
`else
  localparam logic [AW-1:0] AIND_EA = 20'h04080;
  localparam logic [AW-1:0] AIND_HI = 20'h03000;
`endif

  logic          clk_i = 1'b0;
  logic          rsn_i;
  logic          start_i;
  logic [3:0]    mode_i;
  logic [AW-1:0] pc_i;
  logic [7:0]    x_i;
  logic [7:0]    y_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [7:0]    mem_rdata_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] ea_o;
  logic          page_cross_o;
  logic [1:0]    nbytes_o;
  logic          err_o;

  logic          ack_r;
  logic          late_ack;
  assign mem_ack_i = ack_r | late_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int req_cycles = 0;
  exp_t exp_q[$];
  logic [AW-1:0] fetch_addr[$];
  logic [7:0] mem [int unsigned];

  cpu_6502_ea_sequencer #(.ADDR_W(AW), .ZP_BASE(16'h0100)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .start_i(start_i), .mode_i(mode_i),
    .pc_i(pc_i), .x_i(x_i), .y_i(y_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .ea_o(ea_o),
    .page_cross_o(page_cross_o), .nbytes_o(nbytes_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_read(input logic [AW-1:0] a);
    int unsigned k;
    k = 32'(a);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  function automatic exp_t mk(input logic [AW-1:0] ea, input logic pcx,
                              input logic [1:0] nb, input logic err, input int tag);
    exp_t e;
    e.ea = ea; e.pcx = pcx; e.nb = nb; e.err = err; e.tag = tag;
    return e;
  endfunction

  // Memory responder: acks each request after 'lat' wait cycles.
  initial begin : responder
    int wcnt;
    logic [AW-1:0] last_addr;
    ack_r = 1'b0; mem_rdata_i = 8'h00; wcnt = 0; last_addr = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_req_o) req_cycles++;
      if (ack_r) begin
        ack_r = 1'b0;
        wcnt  = 0;
      end else if (mem_req_o && rsn_i) begin
        if (wcnt > 0) chk("addr_stable", 32'(mem_addr_o), 32'(last_addr));
        last_addr = mem_addr_o;
        if (wcnt >= lat) begin
          ack_r       = 1'b1;
          mem_rdata_i = mem_read(mem_addr_o);
          fetch_addr.push_back(mem_addr_o);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares every completion against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("ea[%0d]", e.tag), 32'(ea_o), 32'(e.ea));
          chk($sformatf("page_cross[%0d]", e.tag), 32'(page_cross_o), 32'(e.pcx));
          chk($sformatf("nbytes[%0d]", e.tag), 32'(nbytes_o), 32'(e.nb));
          chk($sformatf("err[%0d]", e.tag), 32'(err_o), 32'(e.err));
          chk($sformatf("busy_in_done[%0d]", e.tag), 32'(busy_o), 32'd1);
        end
        @(negedge clk_i);
        chk("done_one_pulse", 32'(done_o), 32'd0);
        chk("busy_after_done", 32'(busy_o), 32'd0);
      end
    end
  end

  task automatic issue(input logic [3:0] m, input logic [AW-1:0] pc,
                       input logic [7:0] x, input logic [7:0] y, input int l,
                       input bit push, input exp_t e);
    lat = l;
    if (push) exp_q.push_back(e);
    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = m; pc_i = pc; x_i = x; y_i = y;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_o && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({nm, "_timeout"}, 32'(busy_o), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b;
    int rc;
    int n;
    exp_t none;
    none = mk('0, 1'b0, 2'd0, 1'b0, -1);
    mem[32'h00200] = 8'hFF; mem[32'h00201] = 8'h12;
    mem[32'h00300] = 8'hFF; mem[32'h001FF] = 8'hF0; mem[32'h00100] = 8'h20;
    mem[32'h00400] = 8'hFF; mem[32'h00401] = 8'h30;
    mem[32'h030FF] = 8'h80; mem[32'h03000] = 8'h40; mem[32'h03100] = 8'h50;
    mem[32'h010FE] = 8'h02; mem[32'h510FE] = 8'h80;
    mem[32'h30500] = 8'hF0;
    mem[32'h20600] = 8'hFF; mem[32'h20601] = 8'hFF;
    mem[32'h60800] = 8'h10; mem[32'h00105] = 8'h34; mem[32'h00106] = 8'h12;

    rsn_i = 1'b0; start_i = 1'b0; mode_i = 4'd0; pc_i = '0; x_i = 8'h00; y_i = 8'h00;
    late_ack = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ea", 32'(ea_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    @(negedge clk_i) rsn_i = 1'b1;

    // ABSOLUTE_X, 3-cycle ack latency
    issue(4'd4, 20'h00200, 8'h01, 8'h00, 3, 1'b1, mk(20'h01300, 1'b1, 2'd2, 1'b0, 1));
    wait_idle("abs_x");

    // INDIRECT_Y with zero-page pointer wrap
    b = fetch_addr.size();
    issue(4'd10, 20'h00300, 8'h00, 8'h20, 0, 1'b1, mk(20'h02110, 1'b1, 2'd1, 1'b0, 2));
    wait_idle("ind_y");
    chk("ind_y_nfetch", 32'(fetch_addr.size() - b), 32'd3);
    if (fetch_addr.size() >= b + 3) begin
      chk("ind_y_ptr_lo_addr", 32'(fetch_addr[b+1]), 32'h001FF);
      chk("ind_y_ptr_hi_addr", 32'(fetch_addr[b+2]), 32'h00100);
    end

    // ABSOLUTE_INDIRECT across a pointer page boundary
    b = fetch_addr.size();
    issue(4'd11, 20'h00400, 8'h00, 8'h00, 1, 1'b1, mk(AIND_EA, 1'b0, 2'd2, 1'b0, 3));
    wait_idle("aind");
    chk("aind_nfetch", 32'(fetch_addr.size() - b), 32'd4);
    if (fetch_addr.size() >= b + 4)
      chk("aind_hi_addr", 32'(fetch_addr[b+3]), 32'(AIND_HI));

    // RELATIVE forward across a page, then backward within a page in bank 5
    issue(4'd12, 20'h010FE, 8'h00, 8'h00, 2, 1'b1, mk(20'h01101, 1'b1, 2'd1, 1'b0, 4));
    wait_idle("rel_fwd");
    issue(4'd12, 20'h510FE, 8'h00, 8'h00, 0, 1'b1, mk(20'h5107F, 1'b0, 2'd1, 1'b0, 5));
    wait_idle("rel_back");

    // ZERO_PAGE_X from bank 3: index wraps, EA relocated into bank 0
    issue(4'd7, 20'h30500, 8'h20, 8'h00, 0, 1'b1, mk(20'h00110, 1'b0, 2'd1, 1'b0, 6));
    wait_idle("zp_x");

    // Illegal mode: completes the cycle after accept with no memory traffic
    rc = req_cycles;
    issue(4'hE, 20'h00200, 8'h00, 8'h00, 0, 1'b1, mk(20'h00000, 1'b0, 2'd0, 1'b1, 7));
    chk("illegal_done_latency", 32'(done_o), 32'd1);
    chk("illegal_no_req", 32'(mem_req_o), 32'd0);
    wait_idle("illegal");
    chk("illegal_req_cycles", 32'(req_cycles - rc), 32'd0);

    // IMMEDIATE clears err and returns pc with its bank
    issue(4'd2, 20'h40700, 8'h00, 8'h00, 0, 1'b1, mk(20'h40700, 1'b0, 2'd1, 1'b0, 8));
    wait_idle("imm");

    // ABSOLUTE_Y wrapping within bank 2
    issue(4'd5, 20'h20600, 8'h00, 8'h01, 1, 1'b1, mk(20'h20000, 1'b1, 2'd2, 1'b0, 9));
    wait_idle("abs_y_wrap");

    // INDIRECT_X in bank 6
    issue(4'd9, 20'h60800, 8'hF5, 8'h00, 2, 1'b1, mk(20'h61234, 1'b0, 2'd1, 1'b0, 10));
    wait_idle("ind_x");

    // IMPLIED
    issue(4'd0, 20'h12345, 8'h00, 8'h00, 0, 1'b1, mk(20'h00000, 1'b0, 2'd0, 1'b0, 11));
    wait_idle("implied");

    // Reset while the pointer high byte is being requested
    issue(4'd3, 20'h00200, 8'h00, 8'h00, 0, 1'b1, mk(20'h012FF, 1'b0, 2'd2, 1'b0, 12));
    wait_idle("abs");
    b = fetch_addr.size();
    issue(4'd11, 20'h00400, 8'h00, 8'h00, 3, 1'b0, none);
    n = 0;
    while (!(fetch_addr.size() == b + 3 && mem_req_o && !mem_ack_i) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_reach_ptr_hi", 32'(n < 200), 32'd1);
    rsn_i = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_ea", 32'(ea_o), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("midrst_nbytes", 32'(nbytes_o), 32'd0);
    chk("midrst_err_pcx", 32'({err_o, page_cross_o}), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rsn_i = 1'b1;
    @(posedge clk_i); #1 late_ack = 1'b1;
    @(posedge clk_i); #1 late_ack = 1'b0;
    chk("late_ack_busy", 32'(busy_o), 32'd0);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);

    // Normal operation after reset
    issue(4'd11, 20'h00400, 8'h00, 8'h00, 0, 1'b1, mk(AIND_EA, 1'b0, 2'd2, 1'b0, 13));
    wait_idle("aind_after_rst");

    repeat (3) @(posedge clk_i);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
